// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a valid/ready digit-serial scan port.
// Define BCD_SCAN_MSD_FIRST_EN to scan most-significant digit first (default LSD first).

module bcd_scan_digit (
  input  logic [3:0] d,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       step,
  input  logic       up,
  output logic [3:0] nxt,
  output logic       bad,
  output logic       term
);
  assign bad  = ld_val > 4'd9;
  // term: this digit rolls over if stepped, so it propagates carry/borrow upward
  assign term = up ? (d == 4'd9) : (d == 4'd0);

  always_comb begin
    nxt = d;
    if (ld)        nxt = bad ? 4'd0 : ld_val;
    else if (step) nxt = up ? (term ? 4'd0 : d + 4'd1) : (term ? 4'd9 : d - 4'd1);
  end
endmodule

module bcd_scan_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic                  load_err,
  output logic                  dig_valid,
  input  logic                  dig_ready,
  output logic [3:0]            dig_bcd,
  output logic [2:0]            dig_idx,
  output logic                  frame_sof
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
`ifdef BCD_SCAN_MSD_FIRST_EN
  localparam logic [2:0] FIRST = 3'(DIGITS-1);
  localparam logic [2:0] LAST  = 3'd0;
`else
  localparam logic [2:0] FIRST = 3'd0;
  localparam logic [2:0] LAST  = 3'(DIGITS-1);
`endif

  typedef enum logic {SNAP, SEND} state_t;

  logic [DIGITS-1:0][3:0] cnt_q, cnt_d, shadow_q;
  logic [DIGITS-1:0]      bad, term;
  logic [DIGITS:0]        carry;
  logic                   wrap_q, load_err_q;
  state_t                 state_q, state_d;
  logic [2:0]             idx_q;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_scan_digit u_dig (
      .d      (cnt_q[i]),
      .ld     (load),
      .ld_val (load_val[4*i +: 4]),
      .step   (en & carry[i]),
      .up     (up),
      .nxt    (cnt_d[i]),
      .bad    (bad[i]),
      .term   (term[i])
    );
    assign carry[i+1] = carry[i] & term[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wrap_q     <= ~load & en & carry[DIGITS];
      load_err_q <= load & (|bad);
    end
  end

  assign count    = cnt_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

  // Shadow is only written in SNAP, so the frame in flight never sees counter changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SNAP;
      shadow_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == SNAP) begin
        shadow_q <= cnt_q;
        idx_q    <= FIRST;
      end else if (dig_ready && idx_q != LAST) begin
`ifdef BCD_SCAN_MSD_FIRST_EN
        idx_q <= idx_q - 3'd1;
`else
        idx_q <= idx_q + 3'd1;
`endif
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    dig_valid = 1'b0;
    frame_sof = 1'b0;
    dig_bcd   = shadow_q[idx_q[IW-1:0]];
    dig_idx   = idx_q;
    case (state_q)
      SNAP: state_d = SEND;
      SEND: begin
        dig_valid = 1'b1;
        frame_sof = (idx_q == FIRST);
        if (dig_ready && idx_q == LAST) state_d = SNAP;
      end
      default: state_d = SNAP;
    endcase
  end
endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter (DIGITS=4): counting, load, wrap, scan frames, stall, reset.
module tb_bcd_scan_counter;
  localparam int DIGITS = 4;

  logic        clk, rst_n, en, up, load, dig_ready;
  logic [15:0] load_val, count;
  logic        wrap, load_err, dig_valid, frame_sof;
  logic [3:0]  dig_bcd;
  logic [2:0]  dig_idx;

  int n_chk = 0;
  int n_fail = 0;

`ifdef BCD_SCAN_MSD_FIRST_EN
  localparam bit MSD = 1'b1;
`else
  localparam bit MSD = 1'b0;
`endif

  bcd_scan_counter #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count), .wrap(wrap), .load_err(load_err), .dig_valid(dig_valid),
    .dig_ready(dig_ready), .dig_bcd(dig_bcd), .dig_idx(dig_idx), .frame_sof(frame_sof)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pos_idx(input int k);
    return MSD ? (DIGITS-1-k) : k;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_wrap"}, 32'(wrap), 0);
    chk({tag, "_lerr"}, 32'(load_err), 0);
    chk({tag, "_valid"}, 32'(dig_valid), 0);
    chk({tag, "_bcd"}, 32'(dig_bcd), 0);
    chk({tag, "_idx"}, 32'(dig_idx), 0);
    chk({tag, "_sof"}, 32'(frame_sof), 0);
  endtask

  task automatic chk_digit(input string tag, input logic [15:0] val, input int k);
    int ix;
    ix = pos_idx(k);
    chk({tag, "_valid"}, 32'(dig_valid), 1);
    chk({tag, "_idx"}, 32'(dig_idx), 32'(ix));
    chk({tag, "_bcd"}, 32'(dig_bcd), 32'((val >> (4*ix)) & 16'hF));
    chk({tag, "_sof"}, 32'(frame_sof), (k == 0) ? 1 : 0);
  endtask

  // Expects to be on the first digit; leaves on the first digit of the next frame.
  task automatic run_frame(input string tag, input logic [15:0] val);
    for (int k = 0; k < DIGITS; k++) begin
      chk_digit(tag, val, k);
      tick();
    end
    chk({tag, "_gap"}, 32'(dig_valid), 0);
    tick();
  endtask

  task automatic wait_snap(input string tag);
    int n;
    n = 0;
    while (dig_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_snap_timeout"}, 32'(dig_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_w, seen_e;
    int stall_k;
    rst_n = 0; en = 0; up = 0; load = 0; load_val = '0; dig_ready = 1;
    #23;
    chk_zero("reset");
    rst_n = 1;
    tick();

    // 1: count up 12 cycles
    en = 1; up = 1;
    seen_w = 0; seen_e = 0;
    repeat (12) begin
      tick();
      seen_w |= wrap;
      seen_e |= load_err;
    end
    en = 0;
    chk("t1_count", 32'(count), 32'h0012);
    chk("t1_wrap", 32'(seen_w), 0);
    chk("t1_lerr", 32'(seen_e), 0);

    // 2: wrap up and down
    load = 1; load_val = 16'h9999;
    tick();
    load = 0;
    chk("t2_load", 32'(count), 32'h9999);
    chk("t2_load_wrap", 32'(wrap), 0);
    en = 1; up = 1;
    tick();
    en = 0;
    chk("t2_up_count", 32'(count), 32'h0000);
    chk("t2_up_wrap", 32'(wrap), 1);
    tick();
    chk("t2_up_wrap_end", 32'(wrap), 0);
    en = 1; up = 0;
    tick();
    en = 0;
    chk("t2_dn_count", 32'(count), 32'h9999);
    chk("t2_dn_wrap", 32'(wrap), 1);
    tick();
    chk("t2_dn_wrap_end", 32'(wrap), 0);
    chk("t2_dn_hold", 32'(count), 32'h9999);

    // 3: load beats en, bad digit squashed
    load = 1; en = 1; up = 1; load_val = 16'h12A4;
    tick();
    load = 0; en = 0;
    chk("t3_count", 32'(count), 32'h1204);
    chk("t3_lerr", 32'(load_err), 1);
    chk("t3_wrap", 32'(wrap), 0);
    tick();
    chk("t3_lerr_end", 32'(load_err), 0);
    chk("t3_hold", 32'(count), 32'h1204);

    // 4: two frames of a frozen count
    load = 1; load_val = 16'h4721;
    tick();
    load = 0;
    wait_snap("t4");
    tick();
    run_frame("t4_f1", 16'h4721);
    run_frame("t4_f2", 16'h4721);

    // 5: stall on idx 2 while counting; frame stays coherent
    stall_k = MSD ? 1 : 2;
    en = 1; up = 1;
    for (int k = 0; k < DIGITS; k++) begin
      if (k == stall_k) begin
        dig_ready = 0;
        repeat (3) begin
          chk_digit("t5_stall", 16'h4721, k);
          tick();
        end
        dig_ready = 1;
      end
      chk_digit("t5", 16'h4721, k);
      tick();
    end
    en = 0;
    chk("t5_count", 32'(count), 32'h4728);
    chk("t5_gap", 32'(dig_valid), 0);
    tick();
    run_frame("t5_next", 16'h4728);

    // 6: async reset mid-frame
    chk_digit("t6_pre", 16'h4728, 0);
    tick();
    chk_digit("t6_mid", 16'h4728, 1);
    #1;
    rst_n = 0;
    #1;
    chk_zero("t6_rst");
    #1;
    rst_n = 1;
    #1;
    chk("t6_snap", 32'(dig_valid), 0);
    tick();
    run_frame("t6_fresh", 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
